// File: rtl/tdm_demux_1x2.sv
// rtl/tdm_demux_1x2.sv - 2-channel bit-interleaved TDM receiver
// Deinterleaves a serial a0,b0,a1,b1,... stream into two parallel words per frame.
module tdm_demux_1x2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             sel,
  output logic             frame_err
);

  localparam int CW = $clog2(2*WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(2*WIDTH-1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] sh_a, sh_b, sh_a_nx, sh_b_nx;
  logic [WIDTH-1:0] a_nx, b_nx;
  logic             out_valid_nx, frame_err_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sh_a      <= '0;
      sh_b      <= '0;
      a         <= '0;
      b         <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      sh_a      <= sh_a_nx;
      sh_b      <= sh_b_nx;
      a         <= a_nx;
      b         <= b_nx;
      out_valid <= out_valid_nx;
      frame_err <= frame_err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (din_valid) begin
      case (state)
        IDLE: begin
          if (sync) begin
            state_nx = SHIFT;
            cnt_nx   = CNT_ONE;
          end
        end
        SHIFT: begin
          if (sync) begin
            cnt_nx = CNT_ONE;
          end else if (cnt == CNT_LAST) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Words shift in from the MSB so that after WIDTH bits the first (LSB) bit lands at [0].
  always_comb begin
    sh_a_nx      = sh_a;
    sh_b_nx      = sh_b;
    a_nx         = a;
    b_nx         = b;
    out_valid_nx = 1'b0;
    frame_err_nx = 1'b0;
    if (din_valid) begin
      if (sync) begin
        sh_a_nx      = {din, {(WIDTH-1){1'b0}}};
        sh_b_nx      = '0;
        frame_err_nx = (state == SHIFT);
      end else if (state == SHIFT) begin
        if (!cnt[0]) begin
          sh_a_nx = {din, sh_a[WIDTH-1:1]};
        end else begin
          sh_b_nx = {din, sh_b[WIDTH-1:1]};
        end
        if (cnt == CNT_LAST) begin
          a_nx         = sh_a;
          b_nx         = {din, sh_b[WIDTH-1:1]};
          out_valid_nx = 1'b1;
        end
      end
    end
  end

  // The counter is held at zero in IDLE, so its LSB is the mux select in both states.
  assign sel = cnt[0];

endmodule

// File: tb/tb_tdm_demux_1x2.sv
// tb/tb_tdm_demux_1x2.sv - scoreboard bench for tdm_demux_1x2 (WIDTH=4)
module tb_tdm_demux_1x2;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         din;
  logic         din_valid;
  logic         sync;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         sel;
  logic         frame_err;

  tdm_demux_1x2 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .sync      (sync),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .sel       (sel),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  int           fe_q[$];
  int           ov_hist[$];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] hold_a = '0;
  logic [W-1:0] hold_b = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes an output.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid || frame_err)
        chk("ov_fe_exclusive", {31'd0, out_valid & frame_err}, 32'd0);
      if (out_valid) begin
        ov_hist.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word_a", {28'd0, a}, {28'd0, e.ea});
          chk("word_b", {28'd0, b}, {28'd0, e.eb});
          chk("out_valid_cycle", cyc, e.cyc);
          hold_a = e.ea;
          hold_b = e.eb;
        end
      end
      if (frame_err) begin
        if (fe_q.size() == 0) begin
          chk("unexpected_frame_err", 32'd1, 32'd0);
        end else begin
          chk("frame_err_cycle", cyc, fe_q.pop_front());
          chk("a_held_at_err", {28'd0, a}, {28'd0, hold_a});
          chk("b_held_at_err", {28'd0, b}, {28'd0, hold_b});
        end
      end
    end
  end

  task automatic send_bit(input logic d, input logic s, input logic v, input logic es);
    chk("sel", {31'd0, sel}, {31'd0, es});
    din = d; sync = s; din_valid = v;
    @(posedge clk);
    #1;
    din_valid = 1'b0; sync = 1'b0;
  endtask

  task automatic push_ab(input logic [W-1:0] ea, input logic [W-1:0] eb);
    exp_t e;
    e.ea = ea; e.eb = eb; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [W-1:0] fa, input logic [W-1:0] fb,
                            input logic first_sel, input logic expect_err);
    for (int i = 0; i < 2*W; i++) begin
      send_bit((i % 2) ? fb[i/2] : fa[i/2], i == 0, 1'b1,
               (i == 0) ? first_sel : logic'(i % 2));
      if (i == 0 && expect_err) fe_q.push_back(cyc);
    end
    push_ab(fa, fb);
  endtask

  logic [7:0]  basic_bits;
  logic [4:0]  early_bits;
  logic [19:0] junk;

  initial begin
    basic_bits = 8'b0100_1110;   // sent LSB first: 0,1,1,1,0,0,1,0
    early_bits = 5'b01101;       // sent LSB first: 1,0,1,1,0
    junk       = 20'hB5E3C;
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; sync = 1'b0;
    #1;
    chk("reset_a", {28'd0, a}, 32'd0);
    chk("reset_b", {28'd0, b}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_sel", {31'd0, sel}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame: a=A, b=3
    for (int i = 0; i < 8; i++)
      send_bit(basic_bits[i], i == 0, 1'b1, logic'(i % 2));
    push_ab(4'hA, 4'h3);
    repeat (2) send_bit(1'b0, 1'b0, 1'b0, 1'b0);

    // Stall after 4th bit; sync/din toggling while invalid must be ignored
    for (int i = 0; i < 8; i++) begin
      send_bit(basic_bits[i], i == 0, 1'b1, logic'(i % 2));
      if (i == 3) repeat (3) send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    end
    push_ab(4'hA, 4'h3);
    repeat (2) send_bit(1'b0, 1'b0, 1'b0, 1'b0);

    // Early sync after 5 bits, then a=5/b=C
    for (int i = 0; i < 5; i++)
      send_bit(early_bits[i], i == 0, 1'b1, logic'(i % 2));
    send_frame(4'h5, 4'hC, 1'b1, 1'b1);
    repeat (2) send_bit(1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back frames
    ov_hist.delete();
    send_frame(4'hF, 4'h0, 1'b0, 1'b0);
    send_frame(4'h1, 4'h8, 1'b0, 1'b0);
    repeat (2) send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_pulses", ov_hist.size(), 32'd2);
    if (ov_hist.size() == 2)
      chk("b2b_spacing", ov_hist[1] - ov_hist[0], 32'd8);
    chk("b2b_final_a", {28'd0, a}, 32'h1);
    chk("b2b_final_b", {28'd0, b}, 32'h8);

    // Asynchronous reset after 6 bits of a frame
    for (int i = 0; i < 6; i++)
      send_bit(1'b1, i == 0, 1'b1, logic'(i % 2));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a", {28'd0, a}, 32'd0);
    chk("async_rst_b", {28'd0, b}, 32'd0);
    chk("async_rst_sel", {31'd0, sel}, 32'd0);
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_frame_err", {31'd0, frame_err}, 32'd0);
    hold_a = '0; hold_b = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++)
      send_bit(junk[i], 1'b0, 1'b1, 1'b0);
    send_frame(4'h3, 4'h6, 1'b0, 1'b0);
    repeat (2) send_bit(1'b0, 1'b0, 1'b0, 1'b0);

    // Idle garbage: 20 accepted bits, no sync
    ov_hist.delete();
    for (int i = 0; i < 20; i++)
      send_bit(junk[i], 1'b0, 1'b1, 1'b0);
    repeat (2) send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_no_out_valid", ov_hist.size(), 32'd0);
    chk("idle_a_held", {28'd0, a}, 32'h3);
    chk("idle_b_held", {28'd0, b}, 32'h6);

    chk("pending_words", exp_q.size(), 32'd0);
    chk("pending_errs", fe_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1x2.md
Name: tdm_demux_1x2

Overview:
- Receive end of a 2-channel bit-interleaved TDM link. The transmit end is a 2:1 mux toggling its select every bit, so s==0 sends channel a and s==1 sends channel b.
- Deinterleaves a 1-bit serial stream into two WIDTH-bit parallel words and presents them with a one-cycle valid strobe.
- Sits between the serial link input and the downstream parallel consumers.

Parameters:
- WIDTH, 8, bits per channel per frame; must be ≥ 2. A frame is 2*WIDTH serial bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- din  input  1  serial data bit
- din_valid  input  1  din/sync are sampled only when high; low = stall, no state change
- sync  input  1  marks the first bit of a frame (bit a0); qualified by din_valid
- a  output  WIDTH  channel-a word of the last completed frame
- b  output  WIDTH  channel-b word of the last completed frame
- out_valid  output  1  one-cycle pulse: a/b just updated
- sel  output  1  channel of the next expected bit (0 = a, 1 = b), mirroring the transmit mux select
- frame_err  output  1  one-cycle pulse: frame aborted by an early sync

Behaviour:
- Reset (async, rst_n low):
  - a=0, b=0, out_valid=0, frame_err=0, sel=0.
  - State IDLE; bit counter and shift registers cleared.
  - A partial frame in progress is discarded, with no out_valid and no frame_err.
- An "accepted bit" is a rising edge with din_valid=1.
- Frame format:
  - Serial order is a0, b0, a1, b1, …, a(W-1), b(W-1). LSB first per channel, strictly alternating.
  - Even bit index goes to channel a; odd bit index goes to channel b.
- Bit counter: width clog2(2*WIDTH), counts 0..2*WIDTH-1, never wraps mid-frame.
- States:
  - IDLE: accepted bits with sync=0 are ignored. An accepted bit with sync=1 is stored as a0, counter becomes 1, and the state moves to SHIFT.
  - SHIFT, accepted bit with sync=0: the bit goes into the a or b shift register per counter LSB, and the counter increments.
  - SHIFT, accepted bit with sync=1: frame_err pulses the next cycle. The partial frame is discarded and this bit is taken as a0 of a new frame (counter=1, stay in SHIFT). a/b are not updated.
  - SHIFT, accepted bit that is b(W-1) with sync=0 (counter = 2*WIDTH-1):
    - a and b load the assembled words, and out_valid=1 for exactly the cycle after acceptance.
    - Counter clears and the state returns to IDLE.
- Latency: out_valid and the new a/b become visible 1 clock after the final bit is accepted.
- Back-to-back frames: a sync on the cycle immediately after the final bit starts a new frame with no gap cycle.
- Stall: din_valid=0 freezes counter, state and sel for any number of cycles. A stall does not abort a frame.
- sel: 0 in IDLE; in SHIFT it equals the counter LSB. It is registered and updates on accepted bits only.
- Output hold: a/b hold their values until the next completed frame. out_valid and frame_err are never asserted together.
- Simultaneous events: sync=1 while din_valid=0 is ignored.

Test Plan (WIDTH=4):
- Basic frame:
  - Stimulus: rst_n low then high; din_valid=1; serial 0,1,1,1,0,0,1,0 with sync on the first bit.
  - Required: 1 cycle after the last bit, a=4'hA, b=4'h3, out_valid high for exactly 1 cycle. sel sequence during the frame is 0,1,0,1,0,1,0,1.
- Stall mid-frame:
  - Stimulus: same frame with din_valid=0 for 3 cycles after the 4th bit.
  - Required: identical a=4'hA, b=4'h3; out_valid arrives 3 cycles later than in the basic frame; sel holds during the stall.
- Early sync:
  - Stimulus: sync after 5 bits, then a full frame sending a=4'h5, b=4'hC.
  - Required: frame_err pulses once; a/b unchanged at that point; then a=4'h5, b=4'hC with one out_valid.
- Back-to-back frames:
  - Stimulus: two frames with no gap (a=4'hF/b=4'h0, then a=4'h1/b=4'h8).
  - Required: two out_valid pulses exactly 8 cycles apart; final a=4'h1, b=4'h8.
- Reset mid-frame:
  - Stimulus: assert rst_n asynchronously after 6 bits of a frame.
  - Required: a, b, sel, out_valid and frame_err go to 0 immediately, without waiting for a clock edge. Bits after release without sync produce nothing until the next sync.
- Idle garbage:
  - Stimulus: 20 accepted bits with sync=0 from IDLE.
  - Required: no out_valid, no frame_err, sel stays 0.
